// File: rtl/mem_stage.sv
// Memory stage of the 16-bit pipelined core: EX/MEM register, req/ack data
// memory access with timeout, registered writeback bundle and branch redirect.
module mem_stage #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] ALU_out,
    input  logic [15:0] data_2_out,
    input  logic        branch,
    input  logic [15:0] branch_PC,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic [2:0]  wr_reg,
    input  logic        halt_in,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wr,
    output logic        mem_req,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_reg,
    output logic        wb_we,
    output logic        redirect,
    output logic [15:0] redirect_PC,
    output logic        err,
    output logic        halted
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg;
    logic [15:0]      exm_alu_reg;
    logic [15:0]      exm_bpc_reg;
    logic [2:0]       exm_reg_reg;
    logic             exm_branch_reg;
    logic             exm_rw_reg;
    logic             exm_read_reg;
    logic             exm_bad_reg;
    logic             act_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic ack_ok;
    logic capture;
    logic is_mem;
    logic is_bad;
    logic is_legal;

    // An ack only counts once the request is actually on the bus; BUSY is
    // entered on the capture edge so the first BUSY cycle launches mem_req.
    assign ack_ok   = mem_ack & mem_req;
    assign stall    = halted | ((state_reg == BUSY) & ~ack_ok);
    assign capture  = valid_in & ~stall;
    assign is_mem   = mem_read | mem_write;
    assign is_bad   = is_mem & (ALU_out[0] | (mem_read & mem_write));
    assign is_legal = is_mem & ~is_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            exm_alu_reg    <= '0;
            exm_bpc_reg    <= '0;
            exm_reg_reg    <= '0;
            exm_branch_reg <= 1'b0;
            exm_rw_reg     <= 1'b0;
            exm_read_reg   <= 1'b0;
            exm_bad_reg    <= 1'b0;
            act_reg        <= 1'b0;
            cnt_reg        <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wr         <= 1'b0;
            mem_req        <= 1'b0;
            wb_valid       <= 1'b0;
            wb_data        <= '0;
            wb_reg         <= '0;
            wb_we          <= 1'b0;
            redirect       <= 1'b0;
            redirect_PC    <= '0;
            err            <= 1'b0;
            halted         <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            redirect <= 1'b0;

            // Non-memory, branch, halt and faulting memory ops retire here.
            if (act_reg) begin
                act_reg  <= 1'b0;
                wb_valid <= 1'b1;
                wb_data  <= exm_alu_reg;
                wb_reg   <= exm_reg_reg;
                wb_we    <= exm_bad_reg ? 1'b0 : exm_rw_reg;
                if (exm_bad_reg) begin
                    err <= 1'b1;
                end
                if (exm_branch_reg) begin
                    redirect    <= 1'b1;
                    redirect_PC <= exm_bpc_reg;
                end
            end

            if (state_reg == BUSY) begin
                if (!mem_req) begin
                    mem_req <= 1'b1;
                    cnt_reg <= '0;
                end else if (mem_ack) begin
                    mem_req   <= 1'b0;
                    state_reg <= IDLE;
                    wb_valid  <= 1'b1;
                    wb_data   <= exm_read_reg ? mem_rdata : exm_alu_reg;
                    wb_reg    <= exm_reg_reg;
                    wb_we     <= exm_read_reg;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    mem_req   <= 1'b0;
                    state_reg <= IDLE;
                    err       <= 1'b1;
                    wb_valid  <= 1'b1;
                    wb_data   <= exm_alu_reg;
                    wb_reg    <= exm_reg_reg;
                    wb_we     <= 1'b0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // A capture on the ack edge overrides the return to IDLE above.
            if (capture) begin
                exm_alu_reg    <= ALU_out;
                exm_bpc_reg    <= branch_PC;
                exm_reg_reg    <= wr_reg;
                exm_branch_reg <= branch;
                exm_rw_reg     <= reg_write;
                exm_read_reg   <= mem_read;
                exm_bad_reg    <= is_bad;
                act_reg        <= ~is_legal;
                if (halt_in) begin
                    halted <= 1'b1;
                end
                if (is_legal) begin
                    state_reg <= BUSY;
                    mem_addr  <= ALU_out;
                    mem_wdata <= data_2_out;
                    mem_wr    <= mem_write;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-cycle expectation schedule built from
// transaction-level rules, checked against the DUT on every falling edge.
module tb_mem_stage;

    localparam int TMO  = 4;
    localparam int MAXC = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] ALU_out;
    logic [15:0] data_2_out;
    logic        branch;
    logic [15:0] branch_PC;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [2:0]  wr_reg;
    logic        halt_in;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wr;
    logic        mem_req;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_reg;
    logic        wb_we;
    logic        redirect;
    logic [15:0] redirect_PC;
    logic        err;
    logic        halted;

    mem_stage #(.TIMEOUT(TMO), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ALU_out(ALU_out),
        .data_2_out(data_2_out), .branch(branch), .branch_PC(branch_PC),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .wr_reg(wr_reg), .halt_in(halt_in), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg), .wb_we(wb_we),
        .redirect(redirect), .redirect_PC(redirect_PC), .err(err), .halted(halted)
    );

    always #5 clk = ~clk;

    // Expectations indexed by the number of rising edges elapsed.
    logic        e_req[MAXC];
    logic [15:0] e_addr[MAXC];
    logic [15:0] e_wd[MAXC];
    logic        e_wr[MAXC];
    logic        e_stall[MAXC];
    logic        e_wb[MAXC];
    logic [15:0] e_wbd[MAXC];
    logic [2:0]  e_wbr[MAXC];
    logic        e_wbw[MAXC];
    logic        e_rd[MAXC];
    logic [15:0] e_rpc[MAXC];
    logic        e_err[MAXC];
    logic        e_halt[MAXC];
    logic        ack_at[MAXC];
    logic [15:0] rd_at[MAXC];

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int last_p  = 0;
    bit chk_en  = 1'b0;

    task automatic clear_from(input int r);
        for (int i = r; i < MAXC; i++) begin
            e_req[i] = 0; e_addr[i] = 0; e_wd[i] = 0; e_wr[i] = 0; e_stall[i] = 0;
            e_wb[i] = 0; e_wbd[i] = 0; e_wbr[i] = 0; e_wbw[i] = 0;
            e_rd[i] = 0; e_rpc[i] = 0; e_err[i] = 0; e_halt[i] = 0;
            ack_at[i] = 0; rd_at[i] = 0;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic sched_wb(input int e, input logic [15:0] d, input logic [2:0] r, input logic w);
        e_wb[e] = 1; e_wbd[e] = d; e_wbr[e] = r; e_wbw[e] = w;
    endtask

    task automatic set_err(input int e);
        for (int i = e; i < MAXC; i++) e_err[i] = 1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait until the falling edge that follows rising edge e.
    task automatic at_edge(input int e);
        while (cyc < e) step(1);
        @(negedge clk);
    endtask

    // lat = cycle of mem_req in which ack arrives; 0 = never ack.
    task automatic issue(input string tag, input logic rd, input logic wr, input logic br,
                         input logic hlt, input logic rw, input logic [2:0] r,
                         input logic [15:0] alu, input logic [15:0] wd,
                         input logic [15:0] bpc, input int lat, input logic [15:0] rdat);
        int  p;
        int  n;
        logic bad;
        logic legal;
        p = cyc + 1;
        last_p = p;
        valid_in = 1; mem_read = rd; mem_write = wr; branch = br; halt_in = hlt;
        reg_write = rw; wr_reg = r; ALU_out = alu; data_2_out = wd; branch_PC = bpc;
        if (e_stall[cyc] || e_halt[cyc]) begin
            $display("[TB] %s: presented while stalled, expected to be ignored", tag);
        end else begin
            bad   = (rd | wr) & (alu[0] | (rd & wr));
            legal = (rd | wr) & ~bad;
            if (hlt) for (int i = p; i < MAXC; i++) e_halt[i] = 1;
            if (legal) begin
                n = (lat > 0) ? lat : TMO;
                for (int k = 1; k <= n; k++) begin
                    e_req[p+k] = 1; e_addr[p+k] = alu; e_wd[p+k] = wd; e_wr[p+k] = wr;
                end
                for (int k = 0; k < n; k++) e_stall[p+k] = 1;
                if (lat > 0) begin
                    ack_at[p+lat] = 1;
                    rd_at[p+lat]  = rdat;
                    sched_wb(p + lat + 1, rd ? rdat : alu, r, rd);
                end else begin
                    e_stall[p+n] = 1;
                    sched_wb(p + n + 1, alu, r, 1'b0);
                    set_err(p + n + 1);
                end
            end else begin
                sched_wb(p + 1, alu, r, bad ? 1'b0 : rw);
                if (bad) set_err(p + 1);
                if (br) begin
                    e_rd[p+1]  = 1;
                    e_rpc[p+1] = bpc;
                end
            end
            $display("[TB] %s: captured at edge %0d alu=%h rd=%0b wr=%0b br=%0b halt=%0b",
                     tag, p, alu, rd, wr, br, hlt);
        end
        step(1);
        valid_in = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_from(cyc + 1);
        $display("[TB] reset at edge %0d", cyc + 1);
        step(1);
        rst = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        mem_ack = 0;
        mem_rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = ack_at[cyc];
            mem_rdata = rd_at[cyc];
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("stall", {15'd0, stall}, {15'd0, e_stall[cyc] | e_halt[cyc]});
                chk("mem_req", {15'd0, mem_req}, {15'd0, e_req[cyc]});
                if (e_req[cyc]) begin
                    chk("mem_addr", mem_addr, e_addr[cyc]);
                    chk("mem_wr", {15'd0, mem_wr}, {15'd0, e_wr[cyc]});
                    if (e_wr[cyc]) chk("mem_wdata", mem_wdata, e_wd[cyc]);
                end
                chk("wb_valid", {15'd0, wb_valid}, {15'd0, e_wb[cyc]});
                if (e_wb[cyc]) begin
                    chk("wb_data", wb_data, e_wbd[cyc]);
                    chk("wb_reg", {13'd0, wb_reg}, {13'd0, e_wbr[cyc]});
                    chk("wb_we", {15'd0, wb_we}, {15'd0, e_wbw[cyc]});
                end
                chk("redirect", {15'd0, redirect}, {15'd0, e_rd[cyc]});
                if (e_rd[cyc]) chk("redirect_PC", redirect_PC, e_rpc[cyc]);
                chk("err", {15'd0, err}, {15'd0, e_err[cyc]});
                chk("halted", {15'd0, halted}, {15'd0, e_halt[cyc]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        rst = 1; valid_in = 0; ALU_out = 0; data_2_out = 0; branch = 0; branch_PC = 0;
        mem_read = 0; mem_write = 0; reg_write = 0; wr_reg = 0; halt_in = 0;
        clear_from(0);
        step(2);
        rst = 0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("rst_wb_data", wb_data, 16'd0);
        chk("rst_mem_addr", mem_addr, 16'd0);
        chk("rst_err_halted", {14'd0, err, halted}, 16'd0);
        chk("rst_redirect_PC", redirect_PC, 16'd0);

        // ALU op, then two back-to-back ALU ops with no bubble
        issue("alu", 0, 0, 0, 0, 1, 3'd3, 16'h1234, 16'h0, 16'h0, 0, 16'h0);
        p = last_p;
        at_edge(p + 1);
        chk("alu_wb_data", wb_data, 16'h1234);
        chk("alu_wb_reg", {13'd0, wb_reg}, 16'd3);
        chk("alu_wb_we", {15'd0, wb_we}, 16'd1);
        step(1);
        issue("alu_b2b_0", 0, 0, 0, 0, 1, 3'd1, 16'h0A0A, 16'h0, 16'h0, 0, 16'h0);
        issue("alu_b2b_1", 0, 0, 0, 0, 0, 3'd2, 16'h0B0B, 16'h0, 16'h0, 0, 16'h0);
        step(2);

        // Load, ack in third request cycle
        issue("load", 1, 0, 0, 0, 1, 3'd5, 16'h0040, 16'h0, 16'h0, 3, 16'hBEEF);
        p = last_p;
        at_edge(p + 1);
        chk("load_mem_addr", mem_addr, 16'h0040);
        at_edge(p + 4);
        chk("load_wb_data", wb_data, 16'hBEEF);
        chk("load_wb_we", {15'd0, wb_we}, 16'd1);
        step(1);

        // Store acked in first request cycle, ADD captured on the ack edge
        issue("store", 0, 1, 0, 0, 0, 3'd0, 16'h0010, 16'h00FF, 16'h0, 1, 16'h0);
        p = last_p;
        at_edge(p + 1);
        chk("store_mem_wdata", mem_wdata, 16'h00FF);
        chk("store_mem_wr", {15'd0, mem_wr}, 16'd1);
        issue("add_on_ack", 0, 0, 0, 0, 1, 3'd4, 16'h0077, 16'h0, 16'h0, 0, 16'h0);
        step(3);

        // Misaligned load and illegal read+write
        issue("load_misaligned", 1, 0, 0, 0, 1, 3'd6, 16'h0011, 16'h0, 16'h0, 1, 16'h0);
        p = last_p;
        at_edge(p + 1);
        chk("misaligned_err", {15'd0, err}, 16'd1);
        step(1);
        issue("illegal_rw", 1, 1, 0, 0, 1, 3'd7, 16'h0020, 16'h1111, 16'h0, 1, 16'h0);
        step(4);

        // Timeout, then reset in the middle of a fresh load
        do_reset();
        step(1);
        issue("load_timeout", 1, 0, 0, 0, 1, 3'd2, 16'h0080, 16'h0, 16'h0, 0, 16'h0);
        p = last_p;
        at_edge(p + TMO + 1);
        chk("timeout_err", {15'd0, err}, 16'd1);
        chk("timeout_req", {15'd0, mem_req}, 16'd0);
        step(1);
        issue("load_reset", 1, 0, 0, 0, 1, 3'd2, 16'h0090, 16'h0, 16'h0, 0, 16'h0);
        step(1);
        do_reset();
        step(4);

        // Branch then HALT; later instructions must be ignored
        issue("branch", 0, 0, 1, 0, 0, 3'd0, 16'h0000, 16'h0, 16'h0100, 0, 16'h0);
        p = last_p;
        issue("halt", 0, 0, 0, 1, 0, 3'd0, 16'h0000, 16'h0, 16'h0, 0, 16'h0);
        at_edge(p + 1);
        chk("branch_redirect_PC", redirect_PC, 16'h0100);
        issue("after_halt_alu", 0, 0, 0, 0, 1, 3'd1, 16'h5555, 16'h0, 16'h0, 0, 16'h0);
        issue("after_halt_load", 1, 0, 0, 0, 1, 3'd1, 16'h0044, 16'h0, 16'h0, 1, 16'h0);
        step(3);
        @(negedge clk);
        chk("halted_sticky", {15'd0, halted}, 16'd1);
        chk("halted_stall", {15'd0, stall}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 16-bit pipelined core. Sits directly downstream of execute.
- Latches execute results (ALU result, store data, branch decision/target) into an internal EX/MEM register.
- Runs loads/stores against a variable-latency data memory over a req/ack handshake, and stalls upstream while an access is outstanding.
- Presents a registered writeback bundle and a registered branch redirect to the rest of the pipeline.

Parameters:
- TIMEOUT, 64, max cycles mem_req may stay high without mem_ack before the access is aborted with an error.
- CNT_W, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  execute presents a valid instruction this cycle
- ALU_out  input  16  ALU result; the memory address for loads/stores
- data_2_out  input  16  store data
- branch  input  1  branch taken (resolved in execute)
- branch_PC  input  16  branch target
- mem_read  input  1  instruction is a load
- mem_write  input  1  instruction is a store
- reg_write  input  1  instruction writes the register file
- wr_reg  input  3  destination register
- halt_in  input  1  instruction is HALT
- mem_addr  output  16  data memory address
- mem_wdata  output  16  data memory write data
- mem_wr  output  1  1 = write, 0 = read; valid while mem_req
- mem_req  output  1  access request
- mem_rdata  input  16  read data; valid when mem_ack
- mem_ack  input  1  access complete this cycle
- stall  output  1  upstream must hold its inputs; this block ignores valid_in
- wb_valid  output  1  one-cycle pulse: writeback bundle valid
- wb_data  output  16  load data or ALU result
- wb_reg  output  3  destination register
- wb_we  output  1  register file write enable
- redirect  output  1  one-cycle pulse: fetch must load redirect_PC
- redirect_PC  output  16  branch target
- err  output  1  sticky error (misaligned, illegal, or timeout)
- halted  output  1  sticky halt

Behaviour:
- Reset (synchronous): state=IDLE, EX/MEM register cleared, counter=0. All outputs 0: mem_req, stall, wb_valid, wb_we, redirect, err, halted, and every data bus.
- States: IDLE, BUSY.
- stall = halted | (state==BUSY & ~mem_ack). This is combinational.
- Capture: on an edge where valid_in & ~stall, latch all inputs into EX/MEM.
- Next-cycle action for a captured instruction:
  - Non-memory instruction: wb_valid=1, wb_data=ALU value, wb_we=reg_write, wb_reg=wr_reg, one cycle after capture. No stall bubble.
  - branch=1: redirect=1 and redirect_PC=branch_PC, one cycle after capture. Branch uses this same path; wb per reg_write.
  - Load/store with address bit 0 = 0: enter BUSY and drive mem_req=1 from the next cycle. mem_addr, mem_wdata and mem_wr stay stable until ack.
  - Address bit 0 = 1 (misaligned), or mem_read & mem_write both set (illegal): no request. err=1 sticky. wb_valid pulses with wb_we=0.
  - halt_in captured: halted=1 sticky from the next cycle and stall stays high. Instructions already in EX/MEM complete; later inputs are ignored until rst.
- BUSY:
  - Counter increments each cycle.
  - mem_ack=1: mem_req drops at the next edge and state returns to IDLE. stall is already 0 in the ack cycle, so a new instruction may be captured on that edge.
  - On ack, wb_valid pulses the next cycle with wb_data = mem_rdata (load) or the ALU value (store). wb_we is 1 for a load, 0 for a store.
  - Ack and new capture on the same edge are both honoured; the new instruction's action begins the following cycle.
  - Timeout: counter reaching TIMEOUT without ack sets err, drops mem_req, returns to IDLE, and pulses wb_valid with wb_we=0.
- mem_ack while not BUSY is ignored.
- rst during BUSY: mem_req=0 after the reset edge. No wb_valid for the aborted access.
- wb_valid and redirect are single-cycle pulses, never back-to-back for the same instruction.
- Address arithmetic: none. ALU_out is used verbatim.

Test Plan:
- ALU op: ALU_out=0x1234, reg_write=1, wr_reg=3 -> next cycle wb_valid=1, wb_data=0x1234, wb_reg=3, wb_we=1; stall never 1.
- Load, ack after 3 cycles with mem_rdata=0xBEEF, addr 0x0040 -> mem_req high 3 cycles with mem_addr=0x0040, mem_wr=0; stall high until the ack cycle; wb_data=0xBEEF, wb_we=1 the cycle after ack.
- Store to 0x0010, data 0x00FF, ack after 1 cycle; next ADD presented during the ack cycle -> mem_wr=1, mem_wdata=0x00FF; ADD captured on the ack edge; store wb (wb_we=0) and ADD wb appear on consecutive cycles.
- Load at 0x0011 -> no mem_req, err=1 next cycle, wb_we=0; err stays 1 until rst.
- Load with mem_ack held 0 and TIMEOUT=4 -> mem_req high exactly 4 cycles, then err=1 and state IDLE; then rst mid-access on a fresh load -> mem_req=0 after the reset edge, no wb_valid.
- Branch with branch_PC=0x0100 followed by HALT -> redirect=1 with redirect_PC=0x0100 for one cycle; halted=1 and stall=1 persistently after HALT; further valid_in ignored.
